xy_route_ctrl: RTL and testbench



---
 rtl/xy_noc_pkg.sv | 57 +++++
 rtl/xy_route_chan.sv | 115 +++++++++++
 rtl/xy_route_ctrl.sv | 87 ++++++++
 tb/tb_xy_route_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xy_noc_pkg.sv
// Shared definitions for the mesh-switch XY routing logic: flit type codes,
// switch placement codes, direction enum and the direction-to-port map.
package xy_noc_pkg;

  localparam logic [1:0] FLIT_SINGLE = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_BODY   = 2'b10;
  localparam logic [1:0] FLIT_TAIL   = 2'b11;

  // Switch placement: CENTER has all four neighbours, EDGE_* lacks the one
  // named neighbour, SIDE_* sits in a corner and lacks the two named ones.
  localparam logic [3:0] CENTER  = 4'd0;
  localparam logic [3:0] EDGE_LT = 4'd1;
  localparam logic [3:0] EDGE_RT = 4'd2;
  localparam logic [3:0] EDGE_UP = 4'd3;
  localparam logic [3:0] EDGE_DN = 4'd4;
  localparam logic [3:0] SIDE_LU = 4'd5;
  localparam logic [3:0] SIDE_RU = 4'd6;
  localparam logic [3:0] SIDE_LD = 4'd7;
  localparam logic [3:0] SIDE_RD = 4'd8;

  typedef enum logic [2:0] {
    DIR_RESOURCE = 3'd0,
    DIR_LEFT     = 3'd1,
    DIR_UP       = 3'd2,
    DIR_RIGHT    = 3'd3,
    DIR_DOWN     = 3'd4
  } dir_e;

  typedef struct packed {
    logic [2:0] port;
    logic       exists;
  } port_map_t;

  // Existing directions keep their CENTER port number; a missing neighbour
  // falls back to the local resource port 0 and reports exists=0.
  function automatic port_map_t dir2port(input logic [3:0] sw_config, input dir_e dir);
    port_map_t pm;
    logic no_l, no_r, no_u, no_d;
    no_l = (sw_config == EDGE_LT) || (sw_config == SIDE_LU) || (sw_config == SIDE_LD);
    no_r = (sw_config == EDGE_RT) || (sw_config == SIDE_RU) || (sw_config == SIDE_RD);
    no_u = (sw_config == EDGE_UP) || (sw_config == SIDE_LU) || (sw_config == SIDE_RU);
    no_d = (sw_config == EDGE_DN) || (sw_config == SIDE_LD) || (sw_config == SIDE_RD);
    pm.port   = 3'(dir);
    pm.exists = 1'b1;
    case (dir)
      DIR_LEFT:  pm.exists = !no_l;
      DIR_RIGHT: pm.exists = !no_r;
      DIR_UP:    pm.exists = !no_u;
      DIR_DOWN:  pm.exists = !no_d;
      default:   pm.exists = 1'b1;
    endcase
    if (!pm.exists) pm.port = 3'd0;
    return pm;
  endfunction

endpackage

// File: rtl/xy_route_chan.sv
// Single input channel: wormhole route lock. The header flit picks an XY
// output port which stays locked until the tail flit is consumed.
// Error event output is only generated when XY_ROUTE_ERR_EN is defined.
module xy_route_chan
  import xy_noc_pkg::*;
#(
  parameter int         COL_CORD          = 0,
  parameter int         ROW_CORD          = 0,
  parameter int         PACKET_ADDR_COL_W = 4,
  parameter int         PACKET_ADDR_ROW_W = 4,
  parameter int         FLIT_W            = 16,
  parameter int         OUTPUT_N_W        = 3,
  parameter logic [3:0] SW_CONFIG         = CENTER
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [FLIT_W-1:0]     flit_i,
  input  logic                  flit_vld_i,
  input  logic                  flit_hs_i,
  output logic [OUTPUT_N_W-1:0] route_sel_o,
  output logic                  route_vld_o,
  output logic                  hdr_ack_o,
  output logic                  err_evt_o
);

  localparam logic [PACKET_ADDR_COL_W-1:0] MY_COL = PACKET_ADDR_COL_W'(COL_CORD);
  localparam logic [PACKET_ADDR_ROW_W-1:0] MY_ROW = PACKET_ADDR_ROW_W'(ROW_CORD);

  typedef enum logic {S_IDLE, S_ROUTE} state_e;

  state_e                       state_q, state_d;
  logic [OUTPUT_N_W-1:0]        sel_q, sel_d;
  logic                         ack_q, ack_d;
  logic [1:0]                   flit_type;
  logic [PACKET_ADDR_COL_W-1:0] col;
  logic [PACKET_ADDR_ROW_W-1:0] row;
  logic                         is_hdr, is_tail;
  dir_e                         dir;
  port_map_t                    pm;
  logic                         unused_flit;

  assign flit_type   = flit_i[FLIT_W-1 -: 2];
  assign col         = flit_i[PACKET_ADDR_COL_W-1:0];
  assign row         = flit_i[PACKET_ADDR_COL_W +: PACKET_ADDR_ROW_W];
  assign is_hdr      = (flit_type == FLIT_HEAD) || (flit_type == FLIT_SINGLE);
  assign is_tail     = (flit_type == FLIT_TAIL) || (flit_type == FLIT_SINGLE);
  assign unused_flit = ^flit_i;

  // XY decision: resolve the column first, then the row.
  always_comb begin
    dir = DIR_RESOURCE;
    if (col > MY_COL)      dir = DIR_RIGHT;
    else if (col < MY_COL) dir = DIR_LEFT;
    else if (row < MY_ROW) dir = DIR_UP;
    else if (row > MY_ROW) dir = DIR_DOWN;
  end

  assign pm = dir2port(SW_CONFIG, dir);

  // Next-state: lock on a header in IDLE, release on a consumed tail in ROUTE.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flit_vld_i && is_hdr) begin
          state_d = S_ROUTE;
          sel_d   = OUTPUT_N_W'(pm.port);
          ack_d   = 1'b1;
        end
      end
      S_ROUTE: begin
        if (flit_vld_i && flit_hs_i && is_tail) begin
          state_d = S_IDLE;
          sel_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
    end
  end

  assign route_sel_o = sel_q;
  assign route_vld_o = (state_q == S_ROUTE);
  assign hdr_ack_o   = ack_q;

`ifdef XY_ROUTE_ERR_EN
  // Protocol error or header towards a neighbour this switch does not have.
  always_comb begin
    err_evt_o = 1'b0;
    if (flit_vld_i) begin
      if (state_q == S_IDLE) err_evt_o = is_hdr ? !pm.exists : 1'b1;
      else if (flit_hs_i && (flit_type == FLIT_HEAD)) err_evt_o = 1'b1;
    end
  end
`else
  logic unused_exists;
  assign unused_exists = pm.exists;
  assign err_evt_o     = 1'b0;
`endif

endmodule

// File: rtl/xy_route_ctrl.sv
// Multi-input XY route controller: one wormhole route lock per input
// channel plus (with XY_ROUTE_ERR_EN defined) sticky per-channel error
// flags and a saturating total error counter.
module xy_route_ctrl
  import xy_noc_pkg::*;
#(
  parameter int         COL_CORD          = 0,
  parameter int         ROW_CORD          = 0,
  parameter int         PACKET_ADDR_COL_W = 4,
  parameter int         PACKET_ADDR_ROW_W = 4,
  parameter int         FLIT_W            = 16,
  parameter int         IN_N              = 5,
  parameter int         OUTPUT_N_W        = 3,
  parameter logic [3:0] SW_CONFIG         = CENTER,
  parameter int         ERR_CNT_W         = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [IN_N*FLIT_W-1:0]     flit_i,
  input  logic [IN_N-1:0]            flit_vld_i,
  input  logic [IN_N-1:0]            flit_hs_i,
  output logic [IN_N*OUTPUT_N_W-1:0] route_sel_o,
  output logic [IN_N-1:0]            route_vld_o,
  output logic [IN_N-1:0]            hdr_ack_o,
  output logic [IN_N-1:0]            err_o,
  output logic [ERR_CNT_W-1:0]       err_cnt_o
);

  logic [IN_N-1:0] err_evt;

  for (genvar k = 0; k < IN_N; k++) begin : g_chan
    xy_route_chan #(
      .COL_CORD         (COL_CORD),
      .ROW_CORD         (ROW_CORD),
      .PACKET_ADDR_COL_W(PACKET_ADDR_COL_W),
      .PACKET_ADDR_ROW_W(PACKET_ADDR_ROW_W),
      .FLIT_W           (FLIT_W),
      .OUTPUT_N_W       (OUTPUT_N_W),
      .SW_CONFIG        (SW_CONFIG)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flit_i     (flit_i[k*FLIT_W +: FLIT_W]),
      .flit_vld_i (flit_vld_i[k]),
      .flit_hs_i  (flit_hs_i[k]),
      .route_sel_o(route_sel_o[k*OUTPUT_N_W +: OUTPUT_N_W]),
      .route_vld_o(route_vld_o[k]),
      .hdr_ack_o  (hdr_ack_o[k]),
      .err_evt_o  (err_evt[k])
    );
  end

`ifdef XY_ROUTE_ERR_EN
  localparam int SUM_W = ERR_CNT_W + $clog2(IN_N + 1);

  logic [IN_N-1:0]      err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]     sum;

  // Sticky flags and counter that adds all of this cycle's errors, saturating.
  always_comb begin
    err_d = err_q | err_evt;
    sum   = SUM_W'(cnt_q);
    for (int k = 0; k < IN_N; k++) sum = sum + SUM_W'(err_evt[k]);
    if (sum > SUM_W'({ERR_CNT_W{1'b1}})) cnt_d = '1;
    else                                 cnt_d = sum[ERR_CNT_W-1:0];
  end

  // Error state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;
`else
  assign err_o     = err_evt;
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_xy_route_ctrl.sv
// Self-checking bench for xy_route_ctrl: randomized and directed traffic on
// a CENTER switch at (2,2) with a 2-bit error counter, scoreboarded against
// a packet-level model; plus a one-channel EDGE_RT switch for the missing
// neighbour case. Error outputs are expected only with XY_ROUTE_ERR_EN.
module tb_xy_route_ctrl;
  import xy_noc_pkg::*;

`ifdef XY_ROUTE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [1:0] T_SINGLE = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_BODY   = 2'b10;
  localparam logic [1:0] T_TAIL   = 2'b11;

  typedef struct packed {
    logic [4:0]  vld;
    logic [4:0]  ack;
    logic [4:0]  err;
    logic [14:0] sel;
    logic [1:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [79:0] flit = '0;
  logic [4:0]  vld = '0, hs = '0;
  logic [14:0] sel_o;
  logic [4:0]  rvld_o, ack_o, err_o;
  logic [1:0]  cnt_o;

  logic [15:0] e_flit = '0;
  logic        e_vld = 1'b0, e_hs = 1'b0;
  logic [2:0]  e_sel;
  logic        e_rvld, e_ack, e_err;
  logic [7:0]  e_cnt;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  logic [4:0] st_vld, st_hs;
  logic [1:0] st_type[5];
  int         st_col[5], st_row[5];

  bit m_busy[5];
  int m_sel[5];
  bit m_err[5];
  int m_cnt;

  always #5 clk = ~clk;

  xy_route_ctrl #(
    .COL_CORD(2), .ROW_CORD(2), .PACKET_ADDR_COL_W(4), .PACKET_ADDR_ROW_W(4),
    .FLIT_W(16), .IN_N(5), .OUTPUT_N_W(3), .SW_CONFIG(CENTER), .ERR_CNT_W(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flit_i(flit), .flit_vld_i(vld), .flit_hs_i(hs),
    .route_sel_o(sel_o), .route_vld_o(rvld_o), .hdr_ack_o(ack_o),
    .err_o(err_o), .err_cnt_o(cnt_o)
  );

  xy_route_ctrl #(
    .COL_CORD(2), .ROW_CORD(2), .PACKET_ADDR_COL_W(4), .PACKET_ADDR_ROW_W(4),
    .FLIT_W(16), .IN_N(1), .OUTPUT_N_W(3), .SW_CONFIG(EDGE_RT), .ERR_CNT_W(8)
  ) dut_edge (
    .clk_i(clk), .rst_ni(rst_n), .flit_i(e_flit), .flit_vld_i(e_vld), .flit_hs_i(e_hs),
    .route_sel_o(e_sel), .route_vld_o(e_rvld), .hdr_ack_o(e_ack),
    .err_o(e_err), .err_cnt_o(e_cnt)
  );

  function automatic logic [15:0] mk_flit(input logic [1:0] t, input int c, input int r);
    return {t, 6'd0, 4'(r), 4'(c)};
  endfunction

  // Output port of a CENTER switch at (2,2): column first, then row.
  function automatic int xy_port(input int c, input int r);
    if (c > 2) return 3;
    if (c < 2) return 1;
    if (r < 2) return 2;
    if (r > 2) return 4;
    return 0;
  endfunction

  task automatic cmp(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic set_idle();
    st_vld = '0;
    st_hs  = '0;
    for (int k = 0; k < 5; k++) begin
      st_type[k] = T_BODY;
      st_col[k]  = 0;
      st_row[k]  = 0;
    end
  endtask

  task automatic set_ch(input int k, input bit v, input bit h, input logic [1:0] t,
                        input int c, input int r);
    st_vld[k]  = v;
    st_hs[k]   = h;
    st_type[k] = t;
    st_col[k]  = c;
    st_row[k]  = r;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      m_busy[k] = 0;
      m_sel[k]  = 0;
      m_err[k]  = 0;
    end
    m_cnt = 0;
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic apply_stimulus();
    exp_t e;
    int   nerr;
    bit   hdr;
    @(negedge clk);
    e    = '0;
    nerr = 0;
    for (int k = 0; k < 5; k++) begin
      flit[k*16 +: 16] = mk_flit(st_type[k], st_col[k], st_row[k]);
      vld[k] = st_vld[k];
      hs[k]  = st_hs[k];
      hdr = (st_type[k] == T_HEAD) || (st_type[k] == T_SINGLE);
      if (!m_busy[k]) begin
        if (st_vld[k] && hdr) begin
          m_busy[k] = 1;
          m_sel[k]  = xy_port(st_col[k], st_row[k]);
          e.ack[k]  = 1'b1;
        end else if (st_vld[k]) begin
          m_err[k] = 1;
          nerr++;
        end
      end else if (st_vld[k] && st_hs[k]) begin
        if (st_type[k] == T_HEAD) begin
          m_err[k] = 1;
          nerr++;
        end
        if (st_type[k] == T_TAIL || st_type[k] == T_SINGLE) m_busy[k] = 0;
      end
      e.vld[k]        = m_busy[k];
      e.sel[k*3 +: 3] = 3'(m_sel[k]);
      e.err[k]        = ERR_EN & m_err[k];
    end
    m_cnt = (m_cnt + nerr > 3) ? 3 : m_cnt + nerr;
    e.cnt = ERR_EN ? 2'(m_cnt) : 2'd0;
    exp_q.push_back(e);
  endtask

  // Outputs that must all be zero while reset is asserted.
  task automatic check_output(input string tag);
    cmp({tag, "_route_vld"}, int'(rvld_o), 0);
    cmp({tag, "_hdr_ack"},   int'(ack_o),  0);
    cmp({tag, "_route_sel"}, int'(sel_o),  0);
    cmp({tag, "_err"},       int'(err_o),  0);
    cmp({tag, "_err_cnt"},   int'(cnt_o),  0);
    cmp({tag, "_edge_vld"},  int'(e_rvld), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    vld   = '0;
    hs    = '0;
    e_vld = 1'b0;
    e_hs  = 1'b0;
    #1;
    check_output("midrst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Directed checks on the EDGE_RT switch: RIGHT is missing and falls back to port 0.
  task automatic edge_check();
    @(negedge clk);
    e_flit = mk_flit(T_HEAD, 5, 2); e_vld = 1'b1; e_hs = 1'b0;
    @(posedge clk); #1;
    cmp("edge_right_vld", int'(e_rvld), 1);
    cmp("edge_right_sel", int'(e_sel),  0);
    cmp("edge_right_ack", int'(e_ack),  1);
    cmp("edge_right_err", int'(e_err),  int'(ERR_EN));
    cmp("edge_right_cnt", int'(e_cnt),  ERR_EN ? 1 : 0);
    @(negedge clk);
    e_flit = mk_flit(T_TAIL, 0, 0); e_hs = 1'b1;
    @(posedge clk); #1;
    cmp("edge_tail_vld", int'(e_rvld), 0);
    @(negedge clk);
    e_flit = mk_flit(T_SINGLE, 2, 0); e_hs = 1'b0;
    @(posedge clk); #1;
    cmp("edge_up_sel", int'(e_sel),  2);
    cmp("edge_up_vld", int'(e_rvld), 1);
    @(negedge clk);
    e_hs = 1'b1;
    @(negedge clk);
    e_vld = 1'b0; e_hs = 1'b0;
  endtask

  // Scoreboard monitor: pops one expectation per cycle just after the edge.
  initial begin : monitor
    exp_t       e;
    logic [14:0] m;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("route_vld", int'(rvld_o), int'(e.vld));
        cmp("hdr_ack",   int'(ack_o),  int'(e.ack));
        cmp("err",       int'(err_o),  int'(e.err));
        cmp("err_cnt",   int'(cnt_o),  int'(e.cnt));
        m = '0;
        for (int k = 0; k < 5; k++) if (e.vld[k]) m[k*3 +: 3] = 3'b111;
        if (m != '0) cmp("route_sel", int'(sel_o & m), int'(e.sel & m));
      end
    end
  end

  initial begin : stim
    bit busy_now;
    int r;
    model_reset();
    set_idle();
    #2;
    check_output("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // One packet on ch0 towards RIGHT.
    set_idle(); set_ch(0, 1, 0, T_HEAD, 3, 2); apply_stimulus();
    set_idle(); set_ch(0, 1, 1, T_BODY, 0, 0); apply_stimulus();
    apply_stimulus();
    set_idle(); set_ch(0, 1, 1, T_TAIL, 0, 0); apply_stimulus();
    set_idle(); apply_stimulus();

    // SINGLE to RESOURCE, then an UP header right after the bubble.
    set_idle(); set_ch(1, 1, 1, T_SINGLE, 2, 2); apply_stimulus();
    apply_stimulus();
    set_idle(); set_ch(1, 1, 0, T_HEAD, 2, 0); apply_stimulus();
    set_idle(); set_ch(1, 1, 1, T_TAIL, 0, 0); apply_stimulus();

    // All channels take headers together, five distinct directions.
    set_idle();
    set_ch(0, 1, 0, T_HEAD, 2, 2); set_ch(1, 1, 0, T_HEAD, 0, 2);
    set_ch(2, 1, 0, T_HEAD, 2, 0); set_ch(3, 1, 0, T_HEAD, 4, 1);
    set_ch(4, 1, 0, T_HEAD, 2, 4);
    apply_stimulus();
    for (int k = 0; k < 5; k++) set_ch(k, 1, 1, T_TAIL, 0, 0);
    apply_stimulus();

    // Five simultaneous BODY flits in IDLE: counter saturates.
    set_idle();
    for (int k = 0; k < 5; k++) set_ch(k, 1, 1, T_BODY, 0, 0);
    apply_stimulus();
    set_idle(); apply_stimulus();
    apply_stimulus();

    edge_check();

    // Reset in the middle of a packet, then a stray BODY flit.
    set_idle(); set_ch(0, 1, 0, T_HEAD, 1, 1); apply_stimulus();
    set_idle(); set_ch(0, 1, 1, T_BODY, 0, 0); apply_stimulus();
    do_reset();
    set_idle(); set_ch(0, 1, 1, T_BODY, 0, 0); apply_stimulus();
    set_idle(); apply_stimulus();

    // Randomized traffic, with one reset in the middle.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      set_idle();
      for (int k = 0; k < 5; k++) begin
        busy_now = m_busy[k];
        r = int'($urandom_range(0, 9));
        if (busy_now) st_type[k] = (r < 5) ? T_BODY : (r < 8) ? T_TAIL : (r < 9) ? T_SINGLE : T_HEAD;
        else          st_type[k] = (r < 6) ? T_HEAD : (r < 8) ? T_SINGLE : (r < 9) ? T_BODY : T_TAIL;
        st_vld[k] = ($urandom_range(0, 9) < 7);
        st_hs[k]  = ($urandom_range(0, 9) < 6);
        st_col[k] = int'($urandom_range(0, 4));
        st_row[k] = int'($urandom_range(0, 4));
      end
      apply_stimulus();
    end

    set_idle(); apply_stimulus();
    @(posedge clk);
    #2;
    cmp("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
